// File: rtl/hb_pkg.sv
// Shared types and constants for the heartbeat sequencer: state encoding,
// divider period codes and the bpm/accumulator limits.
package hb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LUB  = 3'd1,
        GAP  = 3'd2,
        DUB  = 3'd3,
        REST = 3'd4
    } hb_state_e;

    localparam logic [3:0]  PER_OFF  = 4'd0;
    localparam logic [3:0]  PER_LUB  = 4'd1;
    localparam logic [3:0]  PER_DUB  = 4'd2;
    localparam logic [3:0]  PER_SLOW = 4'd4;

    localparam logic [7:0]  BPM_MIN  = 8'd30;
    localparam logic [7:0]  BPM_MAX  = 8'd180;
    localparam logic [16:0] ACC_WRAP = 17'd60000;

    function automatic logic [7:0] clamp_bpm(input logic [7:0] b);
        if (b < BPM_MIN)      return BPM_MIN;
        else if (b > BPM_MAX) return BPM_MAX;
        else                  return b;
    endfunction

    function automatic logic [3:0] period_of(input hb_state_e s);
        case (s)
            LUB:     return PER_LUB;
            GAP:     return PER_SLOW;
            DUB:     return PER_DUB;
            REST:    return PER_SLOW;
            default: return PER_OFF;
        endcase
    endfunction

endpackage

// File: rtl/hb_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV clocks; clr_i holds it at 0
// so the first tick after release lands exactly DIV cycles later.
module hb_tick_gen #(
    parameter int unsigned DIV = 12_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)              cnt_d = '0;
        else if (cnt_q == LAST) cnt_d = '0;
        else                    cnt_d = cnt_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Tick is the cycle whose edge wraps the count back to 0.
    assign tick_o = ~clr_i & (cnt_q == LAST);

endmodule

// File: rtl/heartbeat_seq.sv
// Lub-dub heartbeat sequencer driving the LED divider period select.
// Define HB_MISS_CNT_EN to add the saturating dropped-beat counter miss_cnt.
module heartbeat_seq
    import hb_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 12_000_000,
    parameter int unsigned TICK_HZ   = 1000,
    parameter int unsigned LUB_TICKS = 100,
    parameter int unsigned GAP_TICKS = 120,
    parameter int unsigned DUB_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] bpm,
    output logic [3:0] period,
    output logic [2:0] phase,
    output logic       beat_pulse,
    output logic       busy
`ifdef HB_MISS_CNT_EN
    ,
    output logic [7:0] miss_cnt
`endif
);

    localparam int unsigned MAX_LG  = (LUB_TICKS > GAP_TICKS) ? LUB_TICKS : GAP_TICKS;
    localparam int unsigned MAX_DUR = (MAX_LG > DUB_TICKS) ? MAX_LG : DUB_TICKS;
    localparam int unsigned PW      = $clog2(MAX_DUR + 1);
    localparam logic [PW-1:0] LUB_LAST = PW'(LUB_TICKS - 1);
    localparam logic [PW-1:0] GAP_LAST = PW'(GAP_TICKS - 1);
    localparam logic [PW-1:0] DUB_LAST = PW'(DUB_TICKS - 1);

    hb_state_e     state_q, state_d;
    logic [15:0]   acc_q, acc_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [3:0]    period_q, period_d;
    logic          pulse_q, pulse_d;
    logic          tick;
    logic [7:0]    bpm_c;
    logic [16:0]   acc_sum;
    logic          beat_evt;

    hb_tick_gen #(.DIV(CLK_FREQ / TICK_HZ)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (~en),
        .tick_o (tick)
    );

    // The accumulator wraps even when a beat is dropped, keeping the long-run rate exact.
    assign bpm_c    = clamp_bpm(bpm);
    assign acc_sum  = {1'b0, acc_q} + 17'(bpm_c);
    assign beat_evt = tick & (acc_sum >= ACC_WRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            pcnt_q   <= '0;
            period_q <= PER_OFF;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            pcnt_q   <= pcnt_d;
            period_q <= period_d;
            pulse_q  <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        pcnt_d  = pcnt_q;
        if (!en) begin
            state_d = IDLE;
            acc_d   = '0;
            pcnt_d  = '0;
        end else if (state_q == IDLE) begin
            state_d = LUB;
            acc_d   = '0;
            pcnt_d  = LUB_LAST;
        end else if (tick) begin
            acc_d = beat_evt ? 16'(acc_sum - ACC_WRAP) : acc_sum[15:0];
            if (state_q == REST) begin
                if (beat_evt) begin
                    state_d = LUB;
                    pcnt_d  = LUB_LAST;
                end
            end else if (pcnt_q == '0) begin
                case (state_q)
                    LUB: begin state_d = GAP;  pcnt_d = GAP_LAST; end
                    GAP: begin state_d = DUB;  pcnt_d = DUB_LAST; end
                    DUB: begin state_d = REST; pcnt_d = '0;       end
                    default: ;
                endcase
            end else begin
                pcnt_d = pcnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        period_d = period_of(state_d);
        pulse_d  = (state_d == LUB) && (state_q != LUB);
        busy     = (state_q == LUB) || (state_q == GAP) || (state_q == DUB);
    end

    assign period     = period_q;
    assign phase      = state_q;
    assign beat_pulse = pulse_q;

`ifdef HB_MISS_CNT_EN
    logic       beat_drop;
    logic [7:0] miss_q;

    assign beat_drop = en & beat_evt & ((state_q == LUB) || (state_q == GAP) || (state_q == DUB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              miss_q <= '0;
        else if (state_d == IDLE)                miss_q <= '0;
        else if (beat_drop && miss_q != 8'hFF)   miss_q <= miss_q + 1'b1;
    end

    assign miss_cnt = miss_q;
`endif

endmodule

// File: doc/heartbeat_seq.md
Name: heartbeat_seq

Overview:
- Sequences the LED clock divider through a "lub-dub" heartbeat pattern by driving its 4-bit period select.
- Time base is an internal millisecond tick. Beat rate is set by a bpm input through a phase accumulator, so no divider is needed.
- Sits between the top-level user controls (enable, rate) and the divider instance that drives the LED.

Parameters:
- CLK_FREQ, 12_000_000, input clock frequency in Hz.
- TICK_HZ, 1000, internal tick rate in Hz; must divide CLK_FREQ.
- LUB_TICKS, 100, duration of the LUB phase in ticks (≥1).
- GAP_TICKS, 120, duration of the GAP phase in ticks (≥1).
- DUB_TICKS, 100, duration of the DUB phase in ticks (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  run enable; level sensitive.
- bpm  in  8  requested beats per minute; clamped to 30..180.
- period  out  4  divider select: 0 = off, 1..4 = divider codes.
- phase  out  3  current state encoding (see package).
- beat_pulse  out  1  single-cycle strobe on entry to LUB.
- busy  out  1  high while in LUB, GAP or DUB.

Behaviour:
- Reset values: state IDLE, period 0, phase IDLE, beat_pulse 0, busy 0, prescaler 0, acc 0, phase_cnt 0.
- Prescaler:
  - Counts 0..CLK_FREQ/TICK_HZ-1.
  - tick is high for one cycle when the count wraps to 0.
  - Free-running while en=1; held at 0 while en=0.
- bpm_c = min(max(bpm, 30), 180), sampled only on tick cycles.
- Accumulator (16-bit, unsigned), updated on each tick while not IDLE:
  - If acc+bpm_c ≥ 60000: acc ← acc+bpm_c−60000 and beat_evt=1.
  - Else: acc ← acc+bpm_c.
  - Width is sufficient: max 59999+180 < 65536.
- States and period codes (period is registered, changes only on transitions):
  - IDLE: period 0.
  - LUB: period 1.
  - GAP: period 4.
  - DUB: period 2.
  - REST: period 4.
- Transitions:
  - IDLE→LUB: on the first cycle en=1. acc←0, phase_cnt←LUB_TICKS−1, beat_pulse=1.
  - LUB→GAP, GAP→DUB, DUB→REST: on a tick with phase_cnt==0. phase_cnt reloads with the next duration−1; otherwise it decrements on each tick.
  - REST→LUB: on a tick with beat_evt=1. beat_pulse=1, phase_cnt←LUB_TICKS−1.
  - Any state→IDLE: on the cycle after en samples 0. All counters clear and period=0. en overrides every other event.
- Phase durations are exact: LUB lasts LUB_TICKS ticks, measured from entry to exit.
- beat_evt outside REST (only possible if the durations sum beyond the clamped interval) is dropped. The accumulator still wraps, so no phase drift occurs.
- Beat interval is 60000/bpm_c ticks on average. Jitter is ≤1 tick.
- Latency: en rise to beat_pulse is 1 cycle. en fall to period=0 is 1 cycle.
- The divider sees its counter reset whenever period=0, which is acceptable and intended.

Optional Feature:
- HB_MISS_CNT_EN defined: adds output miss_cnt [7:0].
  - Increments (saturating at 255) on every dropped beat_evt.
  - Clears on reset and in IDLE.
- HB_MISS_CNT_EN undefined: port and logic absent; dropped beats are silent.

Decomposition:
- Package hb_pkg holds:
  - State enum: IDLE=0, LUB=1, GAP=2, DUB=3, REST=4 (3 bits).
  - Period code constants: PER_OFF=0, PER_LUB=1, PER_DUB=2, PER_SLOW=4.
  - Constants BPM_MIN=30, BPM_MAX=180, ACC_WRAP=60000.
- One sub-module, hb_tick_gen: the prescaler producing tick, with a clear input.
- The FSM and accumulator stay in heartbeat_seq.

Test Plan:
Sim parameters for all scenarios: CLK_FREQ=1000, TICK_HZ=100 (tick every 10 cycles), LUB/GAP/DUB_TICKS=10/12/10.
1. Reset asserted mid-run with en=1 → all outputs 0 asynchronously; after release, beat_pulse=1 one cycle later, then period=1.
2. bpm=60, en held → period sequence 1 (10 ticks), 4 (12), 2 (10), 4 (rest). beat_pulse repeats every 1000 ticks (10000 cycles).
3. bpm=10 → clamped to 30: beats every 2000 ticks. bpm=255 → clamped to 180: intervals alternate 333/334 ticks.
4. en dropped on cycle 5 of LUB → next cycle period=0, phase=IDLE, busy=0. Re-asserting en gives beat_pulse 1 cycle later.
5. bpm changed 60→120 mid-REST → new rate takes effect from the next tick. Next beat ≤500 ticks after the change.
6. HB_MISS_CNT_EN with DUB_TICKS=400 and bpm=180 → miss_cnt increments once per dropped beat and saturates at 255.
